// File: rtl/aes_mode_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_mode_ctrl : multi-channel ECB/CBC/CTR chaining front end for an AES-128 |
// | core; CTR is built only with AES_MODE_CTR_EN.                  Rev 1.0      |
// +-----------------------------------------------------------------------------+
module aes_mode_ctrl #(
  parameter int           NUM_CH      = 4,
  parameter int           OUT_DEPTH   = 4,
  parameter logic [127:0] INITIAL_VEC = 128'h000102030405060708090A0B0C0D0E0F,
  localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  input  logic [CH_W-1:0] in_ch,
  input  logic [1:0]      in_mode,
  input  logic [127:0]    key,
  input  logic            key_valid,
  input  logic            iv_wr,
  input  logic [CH_W-1:0] iv_ch,
  input  logic [127:0]    iv_data,
  output logic            core_start,
  output logic [127:0]    core_data,
  output logic [127:0]    core_key,
  input  logic            core_done,
  input  logic [127:0]    core_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic [CH_W-1:0] out_ch,
  output logic            busy,
  output logic            err
);
  localparam int              AW       = $clog2(OUT_DEPTH);
  localparam logic [AW:0]     DEPTH_V  = (AW+1)'(OUT_DEPTH);
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W+1)'(NUM_CH);
  localparam logic [1:0]      MODE_ECB = 2'b00;
  localparam logic [1:0]      MODE_CBC = 2'b01;
  localparam logic [1:0]      MODE_CTR = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  state_t state;

  logic [127:0]    chain [NUM_CH];
  logic [CH_W-1:0] blk_ch;
  logic [1:0]      blk_mode;
  logic            dirty;

  logic [127:0]    fifo_data [OUT_DEPTH];
  logic [CH_W-1:0] fifo_ch   [OUT_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;

  logic            accept, push, pop;
  logic            in_ok, iv_ok, blk_ok;
  logic [127:0]    in_chain, acc_core_in, result;
  logic [1:0]      acc_mode;
  logic            acc_bad;

  // Channel range checks collapse to constants when NUM_CH fills the index space.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full_range
      assign in_ok  = 1'b1;
      assign iv_ok  = 1'b1;
      assign blk_ok = 1'b1;
    end else begin : g_part_range
      assign in_ok  = ({1'b0, in_ch}  < NUM_CH_V);
      assign iv_ok  = ({1'b0, iv_ch}  < NUM_CH_V);
      assign blk_ok = ({1'b0, blk_ch} < NUM_CH_V);
    end
  endgenerate

  assign in_ready  = !reset && (state == IDLE) && key_valid && (count != DEPTH_V);
  assign accept    = in_valid && in_ready;
  assign push      = (state == WAIT) && core_done;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_data[rd_ptr];
  assign out_ch    = fifo_ch[rd_ptr];
  assign busy      = (state != IDLE);

  always_comb begin
    in_chain = INITIAL_VEC;
    if (in_ok) in_chain = chain[in_ch];
    acc_mode = MODE_ECB;
    acc_bad  = 1'b0;
    case (in_mode)
      2'b01: acc_mode = MODE_CBC;
`ifdef AES_MODE_CTR_EN
      2'b10: acc_mode = MODE_CTR;
`else
      2'b10: acc_bad  = 1'b1;
`endif
      2'b11: acc_bad  = 1'b1;
      default: acc_mode = MODE_ECB;
    endcase
    case (acc_mode)
      MODE_CBC: acc_core_in = in_data ^ in_chain;
      MODE_CTR: acc_core_in = in_chain;
      default:  acc_core_in = in_data;
    endcase
  end

`ifdef AES_MODE_CTR_EN
  logic [127:0] blk_data;
  assign result = (blk_mode == MODE_CTR) ? (core_out ^ blk_data) : core_out;
  always_ff @(posedge clk) begin
    if (accept) blk_data <= in_data;
  end
`else
  assign result = core_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      core_start <= 1'b0;
      err        <= 1'b0;
      dirty      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) chain[i] <= INITIAL_VEC;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          blk_ch     <= in_ch;
          blk_mode   <= acc_mode;
          core_data  <= acc_core_in;
          core_key   <= key;
          core_start <= 1'b1;
          dirty      <= 1'b0;
          if (acc_bad) err <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (core_done) begin
          if (!dirty && blk_ok) begin
            if (blk_mode == MODE_CBC) chain[blk_ch] <= core_out;
`ifdef AES_MODE_CTR_EN
            else if (blk_mode == MODE_CTR) chain[blk_ch][31:0] <= chain[blk_ch][31:0] + 32'd1;
`endif
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A host write wins over the in-flight block's own chain update.
      if (iv_wr && iv_ok) begin
        chain[iv_ch] <= iv_data;
        if (state != IDLE && iv_ch == blk_ch) dirty <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= result;
        fifo_ch[wr_ptr]   <= blk_ch;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_aes_mode_ctrl.sv
`default_nettype none
// tb_aes_mode_ctrl: directed and randomized checks of the chaining controller
// against a block-level model with a stand-in cipher core of fixed latency.
module tb_aes_mode_ctrl;
  localparam int           NUM_CH = 4;
  localparam int           OUT_DEPTH = 4;
  localparam int           CH_W = 2;
  localparam int           L = 10;
  localparam logic [127:0] IV0 = 128'h000102030405060708090A0B0C0D0E0F;

  logic            clk, reset, in_valid, in_ready, key_valid, iv_wr;
  logic [127:0]    in_data, key, iv_data, core_data, core_key, core_out, out_data;
  logic [CH_W-1:0] in_ch, iv_ch, out_ch;
  logic [1:0]      in_mode;
  logic            core_start, core_done, out_valid, out_ready, busy, err;

  aes_mode_ctrl #(.NUM_CH(NUM_CH), .OUT_DEPTH(OUT_DEPTH), .INITIAL_VEC(IV0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ch(in_ch), .in_mode(in_mode), .key(key),
    .key_valid(key_valid), .iv_wr(iv_wr), .iv_ch(iv_ch), .iv_data(iv_data),
    .core_start(core_start), .core_data(core_data), .core_key(core_key),
    .core_done(core_done), .core_out(core_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .busy(busy), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Stand-in cipher: any keyed, non-linear mixing works for the controller.
  function automatic logic [127:0] ciph(input logic [127:0] d, input logic [127:0] k);
    logic [127:0] x;
    x = (d ^ k) * 128'h9E3779B97F4A7C15F39CC0605CEDC835;
    x = x ^ {x[63:0], x[127:64]} ^ {k[63:0], k[127:64]};
    return x + k;
  endfunction

  // Core model: done pulses L cycles after the start pulse's cycle.
  int           cnt = 0;
  logic [127:0] sd, sk;
  logic         force_done = 1'b0;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (force_done) begin
      core_done <= 1'b1;
      core_out  <= 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    end else if (cnt == 1) begin
      core_done <= 1'b1;
      core_out  <= ciph(sd, sk);
    end
    if (cnt > 0) cnt <= cnt - 1;
    if (core_start) begin
      cnt <= L - 1;
      sd  <= core_data;
      sk  <= core_key;
    end
  end

  // Reference model of the block-level behaviour.
  logic [127:0]    chain_m [NUM_CH];
  logic [127:0]    expq_d[$];
  logic [CH_W-1:0] expq_c[$];
  logic            err_m;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) chain_m[i] = IV0;
    expq_d.delete();
    expq_c.delete();
    err_m = 1'b0;
  endtask

  task automatic model_accept(input logic [127:0] d, input logic [CH_W-1:0] ch,
                              input logic [1:0] m, input logic [127:0] k,
                              output logic [127:0] exp_in);
    logic [127:0] c, o;
    c = chain_m[ch];
    exp_in = d;
    o = ciph(d, k);
    if (m == 2'b01) begin
      exp_in = d ^ c;
      o = ciph(exp_in, k);
      chain_m[ch] = o;
    end else if (m == 2'b10) begin
`ifdef AES_MODE_CTR_EN
      exp_in = c;
      o = ciph(c, k) ^ d;
      chain_m[ch] = {c[127:32], 32'((64'(c[31:0]) + 64'd1) % 64'h1_0000_0000)};
`else
      err_m = 1'b1;
`endif
    end else if (m == 2'b11) begin
      err_m = 1'b1;
    end
    expq_d.push_back(o);
    expq_c.push_back(ch);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; iv_wr = 1'b0; force_done = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [127:0] d, input logic [CH_W-1:0] ch, input logic [1:0] m,
                      output logic [127:0] exp_in);
    int n = 0;
    while (!in_ready && n < 200) begin tick(1); n++; end
    total++;
    if (!in_ready) begin bad++; $display("FAIL send_timeout in_ready=%b required=1", in_ready); end
    in_valid = 1'b1; in_data = d; in_ch = ch; in_mode = m;
    model_accept(d, ch, m, key, exp_in);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 100) begin tick(1); n++; end
    total++;
    if (!out_valid) begin bad++; $display("FAIL %s_timeout out_valid=0 required=1", nm); end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    void'(expq_d.pop_front());
    void'(expq_c.pop_front());
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; iv_wr = 1'b0; key_valid = 1'b1;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    in_data = '0; in_ch = '0; in_mode = '0; iv_ch = '0; iv_data = '0;
    reset = 1'b1;
    tick(2);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state in_ready=%b out_valid=%b core_start=%b err=%b busy=%b required all 0",
               in_ready, out_valid, core_start, err, busy);
    end
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release in_ready=%b required=1", in_ready); end
  endtask

  task automatic test_ecb();
    logic [127:0] ei, d;
    int n = 0;
    d = 128'h00112233445566778899aabbccddeeff;
    send(d, 2'd0, 2'b00, ei);
    total++;
    if (core_start !== 1'b1 || core_data !== d || core_key !== key) begin
      bad++;
      $display("FAIL ecb_issue start=%b data=%h key=%h required 1 %h %h", core_start, core_data, core_key, d, key);
    end
    while (!out_valid && n < 100) begin tick(1); n++; end
    total++;
    if (n != L + 1) begin bad++; $display("FAIL ecb_latency cycles=%0d required=%0d", n, L + 1); end
    total++;
    if (out_data !== expq_d[0] || out_ch !== 2'd0) begin
      bad++; $display("FAIL ecb_out data=%h ch=%0d required %h 0", out_data, out_ch, expq_d[0]);
    end
    pop_one();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL ecb_pop out_valid=%b required=0", out_valid); end
  endtask

  task automatic test_cbc();
    logic [127:0] ei, d;
    // Chain 0 must still hold the reset vector after the ECB block.
    send(128'h00102030405060708090a0b0c0d0e0f0, 2'd0, 2'b01, ei);
    total++;
    if (core_data !== 128'h00112233445566778899aabbccddeeff) begin
      bad++; $display("FAIL cbc_first core_data=%h required=00112233445566778899aabbccddeeff", core_data);
    end
    wait_valid("cbc_first");
    total++;
    if (out_data !== expq_d[0]) begin bad++; $display("FAIL cbc_first_out got=%h required=%h", out_data, expq_d[0]); end
    pop_one();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'd1, 2'b01, ei);
    total++;
    if (core_data !== (d ^ IV0)) begin bad++; $display("FAIL cbc_ch1 core_data=%h required=%h", core_data, d ^ IV0); end
    wait_valid("cbc_ch1");
    pop_one();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'd0, 2'b01, ei);
    total++;
    if (core_data !== ei) begin bad++; $display("FAIL cbc_chain core_data=%h required=%h", core_data, ei); end
    wait_valid("cbc_chain");
    total++;
    if (out_data !== expq_d[0] || out_ch !== 2'd0) begin
      bad++; $display("FAIL cbc_chain_out got=%h ch=%0d required=%h 0", out_data, out_ch, expq_d[0]);
    end
    pop_one();
  endtask

  task automatic test_ctr();
    logic [127:0] ei, d;
    d = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_MODE_CTR_EN
    iv_wr = 1'b1; iv_ch = 2'd2; iv_data = 128'h0123456789abcdef01234567ffffffff;
    tick(1);
    iv_wr = 1'b0;
    chain_m[2] = 128'h0123456789abcdef01234567ffffffff;
    send(d, 2'd2, 2'b10, ei);
    total++;
    if (core_data !== 128'h0123456789abcdef01234567ffffffff) begin
      bad++; $display("FAIL ctr_first core_data=%h required=0123456789abcdef01234567ffffffff", core_data);
    end
    wait_valid("ctr_first");
    total++;
    if (out_data !== (ciph(128'h0123456789abcdef01234567ffffffff, key) ^ d)) begin
      bad++; $display("FAIL ctr_out got=%h required=%h", out_data, ciph(128'h0123456789abcdef01234567ffffffff, key) ^ d);
    end
    pop_one();
    send(d, 2'd2, 2'b10, ei);
    total++;
    if (core_data !== 128'h0123456789abcdef0123456700000000) begin
      bad++; $display("FAIL ctr_wrap core_data=%h required=0123456789abcdef0123456700000000", core_data);
    end
    wait_valid("ctr_wrap");
    pop_one();
`else
    send(d, 2'd2, 2'b10, ei);
    total++;
    if (core_data !== d || err !== 1'b1) begin
      bad++; $display("FAIL ctr_disabled core_data=%h err=%b required=%h 1", core_data, err, d);
    end
    wait_valid("ctr_disabled");
    total++;
    if (out_data !== ciph(d, key)) begin bad++; $display("FAIL ctr_disabled_out got=%h required=%h", out_data, ciph(d, key)); end
    pop_one();
`endif
  endtask

  task automatic test_backpressure();
    logic [127:0] ei;
    int n;
    do_reset();
    for (int i = 0; i < OUT_DEPTH; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, CH_W'(i), 2'b00, ei);
      n = 0;
      while (busy && n < 100) begin tick(1); n++; end
    end
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_full in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    tick(3);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_hold in_ready=%b busy=%b required 0 0", in_ready, busy); end
    total++;
    if (out_data !== expq_d[0] || out_ch !== expq_c[0]) begin
      bad++; $display("FAIL bp_head got=%h ch=%0d required=%h %0d", out_data, out_ch, expq_d[0], expq_c[0]);
    end
    pop_one();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_free in_ready=%b required=1", in_ready); end
    for (int i = 1; i < OUT_DEPTH; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== expq_d[0] || out_ch !== CH_W'(i)) begin
        bad++; $display("FAIL bp_order idx=%0d got=%h ch=%0d required=%h %0d", i, out_data, out_ch, expq_d[0], i);
      end
      pop_one();
    end
  endtask

  task automatic test_iv_collision();
    logic [127:0] ei, d;
    do_reset();
    send({$urandom, $urandom, $urandom, $urandom}, 2'd0, 2'b01, ei);
    tick(3);
    iv_wr = 1'b1; iv_ch = 2'd0; iv_data = {4{32'hAAAAAAAA}};
    tick(1);
    iv_wr = 1'b0;
    chain_m[0] = {4{32'hAAAAAAAA}};
    wait_valid("coll");
    total++;
    if (out_data !== expq_d[0]) begin bad++; $display("FAIL coll_out got=%h required=%h", out_data, expq_d[0]); end
    pop_one();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'd0, 2'b01, ei);
    total++;
    if (core_data !== (d ^ {4{32'hAAAAAAAA}})) begin
      bad++; $display("FAIL coll_chain core_data=%h required=%h", core_data, d ^ {4{32'hAAAAAAAA}});
    end
    tick(3);
    iv_wr = 1'b1; iv_ch = 2'd1; iv_data = {4{32'hBBBBBBBB}};
    tick(1);
    iv_wr = 1'b0;
    chain_m[1] = {4{32'hBBBBBBBB}};
    wait_valid("nocoll");
    pop_one();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'd0, 2'b01, ei);
    total++;
    if (core_data !== ei) begin bad++; $display("FAIL nocoll_chain core_data=%h required=%h", core_data, ei); end
    wait_valid("nocoll2");
    pop_one();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'd1, 2'b01, ei);
    total++;
    if (core_data !== (d ^ {4{32'hBBBBBBBB}})) begin
      bad++; $display("FAIL iv_other core_data=%h required=%h", core_data, d ^ {4{32'hBBBBBBBB}});
    end
    wait_valid("iv_other");
    pop_one();
  endtask

  task automatic test_reset_mid();
    logic [127:0] ei, d;
    logic seen = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 2'd0, 2'b01, ei);
    tick(4);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick(1);
    end
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid activity out_valid/busy=1 required 0 after reset"); end
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'd0, 2'b01, ei);
    total++;
    if (core_data !== (d ^ IV0)) begin bad++; $display("FAIL reset_mid_chain core_data=%h required=%h", core_data, d ^ IV0); end
    wait_valid("reset_mid");
    pop_one();
  endtask

  task automatic test_reserved();
    logic [127:0] ei, d;
    do_reset();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL rsv_pre err=%b required=0", err); end
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 2'd1, 2'b11, ei);
    total++;
    if (core_data !== d || err !== 1'b1) begin bad++; $display("FAIL rsv_issue core_data=%h err=%b required=%h 1", core_data, err, d); end
    wait_valid("rsv");
    total++;
    if (out_data !== ciph(d, key) || out_ch !== 2'd1) begin
      bad++; $display("FAIL rsv_out got=%h ch=%0d required=%h 1", out_data, out_ch, ciph(d, key));
    end
    pop_one();
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    tick(3);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      bad++; $display("FAIL stray_done out_valid=%b busy=%b err=%b required 0 0 1", out_valid, busy, err);
    end
    do_reset();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL rsv_clear err=%b required=0", err); end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [127:0] ei;
    int sent = 0, got = 0, cyc = 0;
    logic acc;
    do_reset();
    while ((sent < N || got < sent) && cyc < 4000) begin
      acc = 1'b0;
      iv_wr = 1'b0;
      if (sent < N && !in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
        in_mode  = 2'($urandom_range(0, 3));
        key      = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!in_valid && !busy && $urandom_range(0, 7) == 0) begin
        iv_wr = 1'b1;
        iv_ch = CH_W'($urandom_range(0, NUM_CH - 1));
        iv_data = {$urandom, $urandom, $urandom, $urandom};
        chain_m[iv_ch] = iv_data;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (expq_d.size() == 0 || out_data !== expq_d[0] || out_ch !== expq_c[0]) begin
          bad++; $display("FAIL rand_out n=%0d got=%h ch=%0d required=%h %0d", got, out_data, out_ch, expq_d[0], expq_c[0]);
        end
        void'(expq_d.pop_front());
        void'(expq_c.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        model_accept(in_data, in_ch, in_mode, key, ei);
        sent++;
        acc = 1'b1;
      end
      tick(1);
      iv_wr = 1'b0;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (got != N || err !== err_m || out_valid !== 1'b0) begin
      bad++; $display("FAIL rand_end got=%0d err=%b out_valid=%b required %0d %b 0", got, err, out_valid, N, err_m);
    end
  endtask

  initial begin
    test_reset();
    test_ecb();
    test_cbc();
    test_ctr();
    test_backpressure();
    test_iv_collision();
    test_reset_mid();
    test_reserved();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
